// File: rtl/wb_stream_mem_arbiter_if.sv
// Bus bundle for wb_stream_mem_arbiter: NUM_M Wishbone B3 master ports
// (m_*) folded into flat vectors, plus the shared memory slave port (s_*).
interface wb_stream_mem_arbiter_if #(
  parameter int WB_AW = 32,
  parameter int WB_DW = 32,
  parameter int NUM_M = 2
);
  localparam int SW = WB_DW / 8;

  logic [NUM_M*WB_AW-1:0] m_adr_i;
  logic [NUM_M*WB_DW-1:0] m_dat_i;
  logic [NUM_M*SW-1:0]    m_sel_i;
  logic [NUM_M-1:0]       m_we_i;
  logic [NUM_M-1:0]       m_cyc_i;
  logic [NUM_M-1:0]       m_stb_i;
  logic [NUM_M*3-1:0]     m_cti_i;
  logic [NUM_M*2-1:0]     m_bte_i;
  logic [WB_DW-1:0]       m_dat_o;
  logic [NUM_M-1:0]       m_ack_o;
  logic [NUM_M-1:0]       m_err_o;
  logic [NUM_M-1:0]       m_rty_o;

  logic [WB_AW-1:0]       s_adr_o;
  logic [WB_DW-1:0]       s_dat_o;
  logic [SW-1:0]          s_sel_o;
  logic                   s_we_o;
  logic                   s_cyc_o;
  logic                   s_stb_o;
  logic [2:0]             s_cti_o;
  logic [1:0]             s_bte_o;
  logic [WB_DW-1:0]       s_dat_i;
  logic                   s_ack_i;
  logic                   s_err_i;
  logic                   s_rty_i;

  // Arbiter view: it masters the shared memory port.
  modport master (
    input  m_adr_i, m_dat_i, m_sel_i, m_we_i,
    input  m_cyc_i, m_stb_i, m_cti_i, m_bte_i,
    output m_dat_o, m_ack_o, m_err_o, m_rty_o,
    output s_adr_o, s_dat_o, s_sel_o, s_we_o,
    output s_cyc_o, s_stb_o, s_cti_o, s_bte_o,
    input  s_dat_i, s_ack_i, s_err_i, s_rty_i
  );

  // Environment view: requesting masters and the memory slave.
  modport slave (
    output m_adr_i, m_dat_i, m_sel_i, m_we_i,
    output m_cyc_i, m_stb_i, m_cti_i, m_bte_i,
    input  m_dat_o, m_ack_o, m_err_o, m_rty_o,
    input  s_adr_o, s_dat_o, s_sel_o, s_we_o,
    input  s_cyc_o, s_stb_o, s_cti_o, s_bte_o,
    output s_dat_i, s_ack_i, s_err_i, s_rty_i
  );
endinterface

// File: rtl/wb_stream_mem_arbiter.sv
// Round-robin Wishbone B3 arbiter sharing one memory port among NUM_M masters.
// Ports: clk, rst_n (async active-low), bus (master modport), grant_o (one-hot).
module wb_stream_mem_arbiter #(
  parameter int WB_AW = 32,
  parameter int WB_DW = 32,
  parameter int NUM_M = 2,
  parameter int IDX_W = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  wb_stream_mem_arbiter_if.master bus,
  output logic [NUM_M-1:0]     grant_o
);
  localparam int SW = WB_DW / 8;

  typedef enum logic {
    S_IDLE,
    S_GRANT
  } state_t;

  state_t           r_state;
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] r_last;
  logic [NUM_M-1:0] r_grant;

  logic             w_any;
  logic [IDX_W-1:0] w_pick;
  logic [IDX_W:0]   w_sh;
  logic [IDX_W:0]   w_sum;
  logic [2*NUM_M-1:0] w_rot;
  logic             w_act;
  logic             w_own_cyc;

  logic [WB_AW-1:0] w_adr [NUM_M];
  logic [WB_DW-1:0] w_dat [NUM_M];
  logic [SW-1:0]    w_sel [NUM_M];
  logic [2:0]       w_cti [NUM_M];
  logic [1:0]       w_bte [NUM_M];

  for (genvar k = 0; k < NUM_M; k++) begin : g_slice
    assign w_adr[k] = bus.m_adr_i[k*WB_AW +: WB_AW];
    assign w_dat[k] = bus.m_dat_i[k*WB_DW +: WB_DW];
    assign w_sel[k] = bus.m_sel_i[k*SW +: SW];
    assign w_cti[k] = bus.m_cti_i[k*3 +: 3];
    assign w_bte[k] = bus.m_bte_i[k*2 +: 2];
  end

  assign w_act     = (r_state == S_GRANT);
  assign w_own_cyc = bus.m_cyc_i[r_idx];

  // Rotate the duplicated request vector so bit 0 is master (last+1);
  // the first set bit is then the round-robin winner.
  always_comb begin
    w_any  = 1'b0;
    w_pick = '0;
    w_sum  = '0;
    w_sh   = {1'b0, r_last} + (IDX_W+1)'(1);
    w_rot  = {bus.m_cyc_i, bus.m_cyc_i} >> w_sh;
    for (int j = 0; j < NUM_M; j++) begin
      if (!w_any && w_rot[j]) begin
        w_any = 1'b1;
        w_sum = w_sh + (IDX_W+1)'(j);
        if (w_sum >= (IDX_W+1)'(NUM_M))
          w_sum = w_sum - (IDX_W+1)'(NUM_M);
        w_pick = w_sum[IDX_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_last  <= IDX_W'(NUM_M - 1);
      r_grant <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_state <= S_GRANT;
            r_idx   <= w_pick;
            r_last  <= w_pick;
            r_grant <= NUM_M'(1) << w_pick;
          end
        end
        S_GRANT: begin
          if (!w_own_cyc) begin
            r_state <= S_IDLE;
            r_grant <= '0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_grant <= '0;
        end
      endcase
    end
  end

  assign grant_o = r_grant;

  // Outputs are gated by the state, which resets asynchronously,
  // so reset clears them without waiting for a clock edge.
  always_comb begin
    bus.s_adr_o = '0;
    bus.s_dat_o = '0;
    bus.s_sel_o = '0;
    bus.s_we_o  = 1'b0;
    bus.s_cyc_o = 1'b0;
    bus.s_stb_o = 1'b0;
    bus.s_cti_o = '0;
    bus.s_bte_o = '0;
    if (w_act) begin
      bus.s_adr_o = w_adr[r_idx];
      bus.s_dat_o = w_dat[r_idx];
      bus.s_sel_o = w_sel[r_idx];
      bus.s_we_o  = bus.m_we_i[r_idx];
      bus.s_cyc_o = w_own_cyc;
      bus.s_stb_o = w_own_cyc & bus.m_stb_i[r_idx];
      bus.s_cti_o = w_cti[r_idx];
      bus.s_bte_o = w_bte[r_idx];
    end
  end

  // r_grant is zero outside GRANT, so it also masks responses in IDLE.
  assign bus.m_ack_o = {NUM_M{bus.s_ack_i}} & r_grant;
  assign bus.m_err_o = {NUM_M{bus.s_err_i}} & r_grant;
  assign bus.m_rty_o = {NUM_M{bus.s_rty_i}} & r_grant;
  assign bus.m_dat_o = bus.s_dat_i;

endmodule

// File: tb/tb_wb_stream_mem_arbiter.sv
// Self-checking bench for wb_stream_mem_arbiter.
// Round-robin reference model plus directed and randomized scenarios.
module tb_wb_stream_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NM = 2;
  localparam int IW = 1;
  localparam int SW = DW / 8;

  logic clk = 1'b0;
  logic rst_n;
  logic [NM-1:0] grant;
  int n_tests = 0;
  int n_fail = 0;
  int mdl_last;

  logic [AW-1:0] fa [NM];
  logic [DW-1:0] fd [NM];
  logic [SW-1:0] fs [NM];
  logic [2:0]    fc [NM];
  logic [1:0]    fb [NM];
  logic          fw [NM];
  logic          fst [NM];

  always #5 clk = ~clk;

  wb_stream_mem_arbiter_if #(
    .WB_AW(AW), .WB_DW(DW), .NUM_M(NM)
  ) bus ();

  wb_stream_mem_arbiter #(
    .WB_AW(AW), .WB_DW(DW), .NUM_M(NM), .IDX_W(IW)
  ) u_dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus),
    .grant_o(grant)
  );

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int k);
    bus.m_cyc_i[k] = 1'b1;
    bus.m_stb_i[k] = fst[k];
    bus.m_we_i[k]  = fw[k];
    bus.m_adr_i[k*AW +: AW] = fa[k];
    bus.m_dat_i[k*DW +: DW] = fd[k];
    bus.m_sel_i[k*SW +: SW] = fs[k];
    bus.m_cti_i[k*3 +: 3] = fc[k];
    bus.m_bte_i[k*2 +: 2] = fb[k];
  endtask

  task automatic rand_fields(input int k);
    fa[k]  = $urandom;
    fd[k]  = $urandom;
    fs[k]  = SW'($urandom);
    fc[k]  = 3'($urandom);
    fb[k]  = 2'($urandom);
    fw[k]  = 1'($urandom);
    fst[k] = 1'($urandom);
  endtask

  task automatic clear_all();
    bus.m_adr_i = '0;
    bus.m_dat_i = '0;
    bus.m_sel_i = '0;
    bus.m_we_i  = '0;
    bus.m_cyc_i = '0;
    bus.m_stb_i = '0;
    bus.m_cti_i = '0;
    bus.m_bte_i = '0;
    bus.s_dat_i = '0;
    bus.s_ack_i = 1'b0;
    bus.s_err_i = 1'b0;
    bus.s_rty_i = 1'b0;
  endtask

  // Reference: first requester after the last winner, wrapping around.
  function automatic int rr_pick(input int last, input logic [NM-1:0] req);
    for (int i = 1; i <= NM; i++) begin
      int k;
      k = (last + i) % NM;
      if (req[k]) return k;
    end
    return -1;
  endfunction

  function automatic logic [NM-1:0] oh(input int k);
    logic [NM-1:0] v;
    v = '0;
    if (k >= 0) v[k] = 1'b1;
    return v;
  endfunction

  task automatic test_reset();
    logic [NM-1:0] e;
    clear_all();
    rst_n = 1'b0;
    #3;
    n_tests++;
    if (grant !== '0 || bus.s_cyc_o !== 1'b0 || bus.m_ack_o !== '0) begin
      n_fail++;
      $display("FAIL reset_idle grant=%b cyc=%b ack=%b want 0", grant, bus.s_cyc_o, bus.m_ack_o);
    end
    tick();
    rst_n = 1'b1;
    mdl_last = NM - 1;
    tick();
    fa[1] = 32'h200; fd[1] = 0; fs[1] = '1; fc[1] = 3'b010;
    fb[1] = 0; fw[1] = 0; fst[1] = 1;
    drive(1);
    tick();
    e = oh(rr_pick(mdl_last, 2'b10));
    mdl_last = 1;
    n_tests++;
    if (grant !== e || bus.s_cyc_o !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_pregrant grant=%b cyc=%b want %b 1", grant, bus.s_cyc_o, e);
    end
    bus.s_ack_i = 1'b1;
    #1;
    n_tests++;
    if (bus.m_ack_o !== 2'b10) begin
      n_fail++;
      $display("FAIL reset_preack got %b want 10", bus.m_ack_o);
    end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (bus.s_cyc_o !== 0 || bus.m_ack_o !== '0 || grant !== '0) begin
      n_fail++;
      $display("FAIL reset_async cyc=%b ack=%b grant=%b want 0", bus.s_cyc_o, bus.m_ack_o, grant);
    end
    bus.s_ack_i = 1'b0;
    fa[0] = 0; fd[0] = 0; fs[0] = '1; fc[0] = 0;
    fb[0] = 0; fw[0] = 0; fst[0] = 1;
    drive(0);
    #2;
    rst_n = 1'b1;
    mdl_last = NM - 1;
    tick();
    e = oh(rr_pick(mdl_last, 2'b11));
    mdl_last = 0;
    n_tests++;
    if (grant !== e) begin
      n_fail++;
      $display("FAIL reset_first_grant got %b want %b", grant, e);
    end
    clear_all();
    tick();
    n_tests++;
    if (grant !== '0) begin
      n_fail++;
      $display("FAIL reset_release got %b want 0", grant);
    end
  endtask

  task automatic test_single_read();
    fa[0] = 32'h100; fd[0] = 0; fs[0] = '1; fc[0] = 0;
    fb[0] = 0; fw[0] = 0; fst[0] = 1;
    drive(0);
    #1;
    n_tests++;
    if (bus.s_cyc_o !== 1'b0) begin
      n_fail++;
      $display("FAIL read_latency cyc=%b want 0", bus.s_cyc_o);
    end
    tick();
    mdl_last = rr_pick(mdl_last, 2'b01);
    n_tests++;
    if (bus.s_cyc_o !== 1 || bus.s_adr_o !== 32'h100 || grant !== oh(mdl_last)) begin
      n_fail++;
      $display("FAIL read_grant cyc=%b adr=%h grant=%b want 1 100 %b", bus.s_cyc_o, bus.s_adr_o, grant, oh(mdl_last));
    end
    bus.s_dat_i = 32'hDEADBEEF;
    bus.s_ack_i = 1'b1;
    #1;
    n_tests++;
    if (bus.m_ack_o !== 2'b01 || bus.m_dat_o !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL read_ack ack=%b dat=%h want 01 deadbeef", bus.m_ack_o, bus.m_dat_o);
    end
    tick();
    clear_all();
    tick();
  endtask

  task automatic test_burst();
    int acks;
    logic [NM-1:0] e;
    acks = 0;
    fa[0] = 32'h40; fd[0] = 1; fs[0] = '1; fc[0] = 0;
    fb[0] = 0; fw[0] = 1; fst[0] = 1;
    drive(0);
    fa[1] = 32'h1000; fd[1] = 2; fs[1] = '1; fc[1] = 3'b010;
    fb[1] = 0; fw[1] = 0; fst[1] = 1;
    drive(1);
    tick();
    mdl_last = rr_pick(mdl_last, 2'b11);
    n_tests++;
    if (grant !== oh(mdl_last) || mdl_last != 1) begin
      n_fail++;
      $display("FAIL burst_grant got %b want %b", grant, oh(mdl_last));
    end
    for (int b = 0; b < 8; b++) begin
      logic [DW-1:0] d;
      d = $urandom;
      fa[1] = 32'h1000 + 32'(4 * b);
      fc[1] = (b == 7) ? 3'b111 : 3'b010;
      drive(1);
      bus.s_ack_i = 1'b1;
      bus.s_dat_i = d;
      #1;
      if (bus.m_ack_o == 2'b10) acks++;
      n_tests++;
      if (bus.s_adr_o !== fa[1] || bus.s_cti_o !== fc[1] || bus.m_dat_o !== d) begin
        n_fail++;
        $display("FAIL burst_beat%0d adr=%h cti=%b dat=%h want %h %b %h", b, bus.s_adr_o, bus.s_cti_o, bus.m_dat_o, fa[1], fc[1], d);
      end
      tick();
    end
    bus.s_ack_i = 1'b0;
    bus.m_cyc_i[1] = 1'b0;
    bus.m_stb_i[1] = 1'b0;
    n_tests++;
    if (acks != 8 || grant !== 2'b10) begin
      n_fail++;
      $display("FAIL burst_acks got %0d grant=%b want 8 10", acks, grant);
    end
    tick();
    n_tests++;
    if (grant !== '0 || bus.s_cyc_o !== 0) begin
      n_fail++;
      $display("FAIL burst_gap grant=%b cyc=%b want 0 0", grant, bus.s_cyc_o);
    end
    tick();
    mdl_last = rr_pick(mdl_last, 2'b01);
    e = oh(mdl_last);
    n_tests++;
    if (grant !== e) begin
      n_fail++;
      $display("FAIL burst_next got %b want %b", grant, e);
    end
    clear_all();
    tick();
  endtask

  task automatic test_error();
    fa[0] = 32'h80; fd[0] = 0; fs[0] = '1; fc[0] = 0;
    fb[0] = 0; fw[0] = 1; fst[0] = 1;
    drive(0);
    tick();
    mdl_last = rr_pick(mdl_last, 2'b01);
    fa[1] = 32'h90; fd[1] = 0; fs[1] = '1; fc[1] = 0;
    fb[1] = 0; fw[1] = 0; fst[1] = 1;
    drive(1);
    bus.s_err_i = 1'b1;
    #1;
    n_tests++;
    if (bus.m_err_o !== 2'b01 || bus.m_ack_o !== '0) begin
      n_fail++;
      $display("FAIL err_route err=%b ack=%b want 01 00", bus.m_err_o, bus.m_ack_o);
    end
    bus.s_err_i = 1'b0;
    bus.s_rty_i = 1'b1;
    #1;
    n_tests++;
    if (bus.m_rty_o !== 2'b01 || bus.m_err_o !== '0) begin
      n_fail++;
      $display("FAIL rty_route rty=%b err=%b want 01 00", bus.m_rty_o, bus.m_err_o);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++;
      if (grant !== 2'b01) begin
        n_fail++;
        $display("FAIL err_hold%0d got %b want 01", i, grant);
      end
    end
    bus.s_rty_i = 1'b0;
    bus.m_cyc_i[0] = 1'b0;
    tick();
    tick();
    mdl_last = rr_pick(mdl_last, 2'b10);
    n_tests++;
    if (grant !== oh(mdl_last)) begin
      n_fail++;
      $display("FAIL err_handover got %b want %b", grant, oh(mdl_last));
    end
    clear_all();
    tick();
  endtask

  task automatic test_ignored();
    clear_all();
    bus.m_stb_i[1] = 1'b1;
    bus.s_ack_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_tests++;
      if (grant !== '0 || bus.m_ack_o !== '0 || bus.s_cyc_o !== 0 || bus.s_stb_o !== 0) begin
        n_fail++;
        $display("FAIL ignored%0d grant=%b ack=%b cyc=%b stb=%b want 0", i, grant, bus.m_ack_o, bus.s_cyc_o, bus.s_stb_o);
      end
    end
    clear_all();
    tick();
  endtask

  task automatic test_round_robin();
    logic [NM-1:0] req;
    logic [NM-1:0] pend;
    int w;
    int nb;
    pend = '0;
    for (int it = 0; it < 28; it++) begin
      req = (it < 8) ? 2'b11 : (pend | NM'($urandom_range(1, 3)));
      for (int k = 0; k < NM; k++) begin
        if (req[k] && !pend[k]) begin
          rand_fields(k);
          drive(k);
        end
      end
      tick();
      w = rr_pick(mdl_last, req);
      mdl_last = w;
      n_tests++;
      if (grant !== oh(w) || bus.s_cyc_o !== 1'b1) begin
        n_fail++;
        $display("FAIL rr_grant it%0d got %b want %b", it, grant, oh(w));
      end
      n_tests++;
      if (bus.s_adr_o !== fa[w] || bus.s_dat_o !== fd[w] ||
          bus.s_sel_o !== fs[w] || bus.s_we_o !== fw[w] ||
          bus.s_cti_o !== fc[w] || bus.s_bte_o !== fb[w] ||
          bus.s_stb_o !== fst[w]) begin
        n_fail++;
        $display("FAIL rr_fwd it%0d adr=%h dat=%h want %h %h", it, bus.s_adr_o, bus.s_dat_o, fa[w], fd[w]);
      end
      nb = $urandom_range(1, 3);
      for (int b = 0; b < nb; b++) begin
        logic [DW-1:0] d;
        d = $urandom;
        bus.s_dat_i = d;
        bus.s_ack_i = 1'b1;
        #1;
        n_tests++;
        if (bus.m_ack_o !== oh(w) || bus.m_dat_o !== d) begin
          n_fail++;
          $display("FAIL rr_ack it%0d ack=%b dat=%h want %b %h", it, bus.m_ack_o, bus.m_dat_o, oh(w), d);
        end
        tick();
      end
      bus.s_ack_i = 1'b0;
      bus.m_cyc_i[w] = 1'b0;
      bus.m_stb_i[w] = 1'b0;
      pend = req & ~oh(w);
      tick();
      n_tests++;
      if (grant !== '0 || bus.s_cyc_o !== 1'b0) begin
        n_fail++;
        $display("FAIL rr_gap it%0d grant=%b cyc=%b want 0 0", it, grant, bus.s_cyc_o);
      end
    end
    clear_all();
    tick();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_burst();
    test_error();
    test_ignored();
    test_round_robin();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
